cat_trap_board: RTL and testbench

- Game-state writer for the Cat Trap display. It owns the 8x8 board (blocked mask plus cat position) and the game state machine.
- It debounces BtnC, applies the player's cursor selection from Row/Col, and moves the cat.
- It serves a registered cell-read port that the VGA renderer scans by grid coordinate. The renderer only reads; this block is the sole writer of board state.

---
 rtl/cat_trap_pkg.sv | 38 +++
 rtl/btn_debounce.sv | 49 ++++
 rtl/cat_trap_board.sv | 137 +++++++++++++
 tb/tb_cat_trap_board.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cat_trap_pkg.sv
// Shared definitions for the Cat Trap game.
// Holds the one-hot game state encodings, the 2-bit cell codes returned by the
// board read port, the grid size, the renderer colour constants, and a
// one-hot-to-index helper used to decode the cursor Row/Col buses.
package cat_trap_pkg;

    localparam int GRID_DIM = 8;

    typedef logic [4:0] state_t;
    typedef logic [1:0] cell_t;

    localparam state_t START    = 5'b00001;
    localparam state_t PLAY     = 5'b00010;
    localparam state_t GAMEOVER = 5'b00100;
    localparam state_t GAMEWIN  = 5'b01000;
    localparam state_t CAT_MOVE = 5'b10000;

    localparam cell_t FREE    = 2'b00;
    localparam cell_t BLOCKED = 2'b01;
    localparam cell_t CAT     = 2'b10;

    // 12-bit RGB colours used by the renderer for free / blocked / cat cells.
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] GRAY   = 12'h888;
    localparam logic [11:0] ORANGE = 12'hF80;

    // Index of the set bit of an 8-bit one-hot vector. Only meaningful when
    // the input is exactly one-hot; validity is checked separately.
    function automatic logic [2:0] oh8_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchroniser, stability counter and rising-edge
// pulse generator.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   btn   - raw asynchronous, bouncy button input
//   pulse - single-cycle pulse on each accepted 0->1 change of the stable level
module btn_debounce #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DB_CYCLES consecutive mismatching samples: accept the level.
                stable <= sync2;
                cnt    <= '0;
                pulse  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cat_trap_board.sv
// Cat Trap game-state writer. Owns the 8x8 blocked mask, the cat position and
// the game FSM; serves a registered cell-read port to the VGA renderer.
// Ports:
//   clk, Reset          - clock, synchronous active-high reset
//   BtnC                - raw select button (debounced internally)
//   Row, Col            - one-hot cursor row / column
//   rd_col, rd_row      - renderer read coordinate
//   rd_cell             - cell code at the read coordinate, 1-cycle latency
//   state               - one-hot game state
//   cat_col, cat_row    - current cat position
//   move_count          - accepted player blocks this game (saturating)
module cat_trap_board
    import cat_trap_pkg::*;
#(
    parameter int DB_CYCLES     = 250000,
    parameter int CAT_START_COL = 3,
    parameter int CAT_START_ROW = 3
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       BtnC,
    input  logic [7:0] Row,
    input  logic [7:0] Col,
    input  logic [2:0] rd_col,
    input  logic [2:0] rd_row,
    output logic [1:0] rd_cell,
    output logic [4:0] state,
    output logic [2:0] cat_col,
    output logic [2:0] cat_row,
    output logic [7:0] move_count
);

    localparam logic [2:0] START_COL = 3'(CAT_START_COL);
    localparam logic [2:0] START_ROW = 3'(CAT_START_ROW);
    localparam logic [2:0] EDGE_HI   = 3'(GRID_DIM - 1);

    // Bit index is {row, col}.
    logic [GRID_DIM*GRID_DIM-1:0] blocked;

    logic press;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk  (clk),
        .rst  (Reset),
        .btn  (BtnC),
        .pulse(press)
    );

    // Cursor decode
    logic       sel_valid;
    logic [5:0] sel_idx;
    logic       sel_is_cat;

    assign sel_valid  = $onehot(Row) && $onehot(Col);
    assign sel_idx    = {oh8_to_idx(Row), oh8_to_idx(Col)};
    assign sel_is_cat = (sel_idx == {cat_row, cat_col});

    // Neighbour evaluation, priority N, E, S, W
    logic       n_free, e_free, s_free, w_free;
    logic       any_free;
    logic [2:0] nxt_col, nxt_row;
    logic       nxt_on_edge;

    assign n_free = (cat_row != 3'd0)    && !blocked[{cat_row - 3'd1, cat_col}];
    assign e_free = (cat_col != EDGE_HI) && !blocked[{cat_row, cat_col + 3'd1}];
    assign s_free = (cat_row != EDGE_HI) && !blocked[{cat_row + 3'd1, cat_col}];
    assign w_free = (cat_col != 3'd0)    && !blocked[{cat_row, cat_col - 3'd1}];
    assign any_free = n_free || e_free || s_free || w_free;

    always_comb begin
        nxt_col = cat_col;
        nxt_row = cat_row;
        if (n_free)      nxt_row = cat_row - 3'd1;
        else if (e_free) nxt_col = cat_col + 3'd1;
        else if (s_free) nxt_row = cat_row + 3'd1;
        else if (w_free) nxt_col = cat_col - 3'd1;
    end

    assign nxt_on_edge = (nxt_row == 3'd0) || (nxt_row == EDGE_HI) ||
                         (nxt_col == 3'd0) || (nxt_col == EDGE_HI);

    // Read port: cat wins over blocked. Built from current registers so a
    // write landing on the same edge is not yet visible.
    logic [1:0] rd_next;

    always_comb begin
        rd_next = FREE;
        if (rd_col == cat_col && rd_row == cat_row) rd_next = CAT;
        else if (blocked[{rd_row, rd_col}])         rd_next = BLOCKED;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= START;
            blocked    <= '0;
            cat_col    <= START_COL;
            cat_row    <= START_ROW;
            move_count <= '0;
            rd_cell    <= FREE;
        end else begin
            rd_cell <= rd_next;
            case (state)
                START: begin
                    if (press) state <= PLAY;
                end
                PLAY: begin
                    if (press && sel_valid && !blocked[sel_idx] && !sel_is_cat) begin
                        blocked[sel_idx] <= 1'b1;
                        if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                        state <= CAT_MOVE;
                    end
                end
                CAT_MOVE: begin
                    // Presses during this cycle are intentionally dropped.
                    if (!any_free) begin
                        state <= GAMEWIN;
                    end else begin
                        cat_col <= nxt_col;
                        cat_row <= nxt_row;
                        state   <= nxt_on_edge ? GAMEOVER : PLAY;
                    end
                end
                GAMEOVER, GAMEWIN: begin
                    if (press) begin
                        state      <= START;
                        blocked    <= '0;
                        cat_col    <= START_COL;
                        cat_row    <= START_ROW;
                        move_count <= '0;
                    end
                end
                default: state <= START;
            endcase
        end
    end

endmodule

// File: tb/tb_cat_trap_board.sv
// Directed bench for cat_trap_board. Stimulus pushes expected observations
// into a queue; a monitor pops and compares whenever a probe strobe is raised.
module tb_cat_trap_board;

    logic       clk = 1'b0;
    logic       Reset;
    logic       BtnC;
    logic [7:0] Row, Col;
    logic [2:0] rd_col, rd_row;
    logic [1:0] rd_cell;
    logic [4:0] state;
    logic [2:0] cat_col, cat_row;
    logic [7:0] move_count;

    localparam logic [4:0] S_START = 5'b00001;
    localparam logic [4:0] S_PLAY  = 5'b00010;
    localparam logic [4:0] S_OVER  = 5'b00100;
    localparam logic [4:0] S_WIN   = 5'b01000;
    localparam logic [4:0] S_MOVE  = 5'b10000;

    cat_trap_board #(.DB_CYCLES(4), .CAT_START_COL(3), .CAT_START_ROW(3)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .BtnC      (BtnC),
        .Row       (Row),
        .Col       (Col),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
        .rd_cell   (rd_cell),
        .state     (state),
        .cat_col   (cat_col),
        .cat_row   (cat_row),
        .move_count(move_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] st;
        logic [2:0] cc;
        logic [2:0] cr;
        logic [7:0] mc;
        logic [1:0] rc;
        bit         chk_rd;
    } exp_t;

    exp_t sb[$];
    logic mon_req = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    // Monitor: compares the DUT outputs against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_req) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: probe raised with no expectation");
                end else begin
                    e = sb.pop_front();
                    if (state !== e.st || cat_col !== e.cc || cat_row !== e.cr ||
                        move_count !== e.mc || (e.chk_rd && rd_cell !== e.rc)) begin
                        errors++;
                        $display("FAIL %s: got st=%b cat=(%0d,%0d) mc=%0d rd=%b, want st=%b cat=(%0d,%0d) mc=%0d rd=%b",
                                 e.name, state, cat_col, cat_row, move_count, rd_cell,
                                 e.st, e.cc, e.cr, e.mc, e.rc);
                    end
                end
            end
        end
    end

    // Read (col,row) and check all outputs one cycle later.
    task automatic probe(input string name, input int c, input int r,
                         input logic [4:0] st, input int cc, input int cr,
                         input int mc, input logic [1:0] rc);
        exp_t e;
        rd_col = 3'(c);
        rd_row = 3'(r);
        @(posedge clk); #1;
        e.name = name; e.st = st; e.cc = 3'(cc); e.cr = 3'(cr);
        e.mc = 8'(mc); e.rc = rc; e.chk_rd = 1'b1;
        sb.push_back(e);
        mon_req = 1'b1;
        @(negedge clk); #1;
        mon_req = 1'b0;
    endtask

    // Hold BtnC for 8 cycles then release for 8; enough for press and release
    // to be accepted and for any CAT_MOVE to resolve.
    task automatic press_raw(input logic [7:0] r_oh, input logic [7:0] c_oh);
        @(posedge clk); #1;
        Row = r_oh; Col = c_oh; BtnC = 1'b1;
        repeat (8) @(posedge clk);
        #1 BtnC = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic press_cell(input int c, input int r);
        logic [7:0] one;
        one = 8'b1;
        press_raw(one << r, one << c);
    endtask

    initial begin
        exp_t e;
        Reset = 1'b1; BtnC = 1'b0; Row = '0; Col = '0; rd_col = 3'd3; rd_row = 3'd3;
        // Reset holds rd_cell at 00 even with the cat at the read address.
        probe("reset_rd", 3, 3, S_START, 3, 3, 0, 2'b00);
        @(posedge clk); #1 Reset = 1'b0;
        probe("reset_cat", 3, 3, S_START, 3, 3, 0, 2'b10);
        probe("reset_free", 0, 0, S_START, 3, 3, 0, 2'b00);

        // 3-cycle glitch must be rejected.
        @(posedge clk); #1 BtnC = 1'b1;
        repeat (3) @(posedge clk);
        #1 BtnC = 1'b0;
        repeat (8) @(posedge clk);
        probe("glitch", 0, 0, S_START, 3, 3, 0, 2'b00);

        // START press goes to PLAY without blocking the cursor cell.
        press_cell(7, 7);
        probe("start_play", 7, 7, S_PLAY, 3, 3, 0, 2'b00);
        probe("start_cat", 3, 3, S_PLAY, 3, 3, 0, 2'b10);

        // Ignored presses.
        press_raw(8'b0000_0011, 8'b1000_0000);
        probe("ign_invalid", 7, 7, S_PLAY, 3, 3, 0, 2'b00);
        press_cell(3, 3);
        probe("ign_cat", 3, 3, S_PLAY, 3, 3, 0, 2'b10);

        // Game 1: cat runs north to the edge.
        press_cell(7, 7);
        probe("g1_m1", 7, 7, S_PLAY, 3, 2, 1, 2'b01);
        press_cell(7, 7);
        probe("ign_blocked", 3, 2, S_PLAY, 3, 2, 1, 2'b10);
        press_cell(7, 6);
        probe("g1_m2", 7, 6, S_PLAY, 3, 1, 2, 2'b01);
        press_cell(7, 5);
        probe("g1_over", 3, 0, S_OVER, 3, 0, 3, 2'b10);

        // GAMEOVER press clears the board.
        press_cell(0, 0);
        probe("over_start", 7, 7, S_START, 3, 3, 0, 2'b00);
        press_cell(0, 0);
        probe("play2", 7, 6, S_PLAY, 3, 3, 0, 2'b00);

        // Game 2: cat gets trapped.
        press_cell(3, 1);
        probe("g2_m1", 3, 1, S_PLAY, 3, 2, 1, 2'b01);
        press_cell(4, 2);
        probe("g2_m2", 4, 2, S_PLAY, 3, 3, 2, 2'b01);
        press_cell(2, 2);
        probe("g2_m3", 2, 2, S_PLAY, 3, 2, 3, 2'b01);
        press_cell(3, 3);
        probe("g2_win", 3, 3, S_WIN, 3, 2, 4, 2'b01);
        probe("g2_win_cat", 3, 2, S_WIN, 3, 2, 4, 2'b10);
        press_cell(0, 0);
        probe("win_start", 4, 2, S_START, 3, 3, 0, 2'b00);
        probe("win_cat", 3, 3, S_START, 3, 3, 0, 2'b10);
        press_cell(0, 0);
        probe("play3", 3, 1, S_PLAY, 3, 3, 0, 2'b00);

        // Reset during CAT_MOVE. BtnC rises before edge 1; the pulse is
        // registered on edge 6, PLAY->CAT_MOVE on edge 7, the move on edge 8.
        @(posedge clk); #1;
        Row = 8'h01; Col = 8'h01; BtnC = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        e.name = "in_move"; e.st = S_MOVE; e.cc = 3'd3; e.cr = 3'd3;
        e.mc = 8'd1; e.rc = 2'b00; e.chk_rd = 1'b0;
        sb.push_back(e);
        mon_req = 1'b1;
        @(negedge clk); #1;
        mon_req = 1'b0;
        Reset = 1'b1; BtnC = 1'b0;
        @(posedge clk); #1 Reset = 1'b0;
        probe("rst_move", 0, 0, S_START, 3, 3, 0, 2'b00);
        probe("rst_move_cat", 3, 3, S_START, 3, 3, 0, 2'b10);
        probe("rst_move_n", 3, 2, S_START, 3, 3, 0, 2'b00);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
